// File: rtl/vmx_buf_host.sv
// vmx_buf_host: input/result buffers and job sequencer for the VMX matrix-multiply wrapper
module vmx_buf_host #(
  parameter int PE_SIZE = 4,
  parameter int N_IN = 2 * PE_SIZE,
  parameter int N_OUT = PE_SIZE,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic [7:0]   cfg_rbase,
  input  logic [7:0]   cfg_wbase,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [63:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic [7:0]   rbase_addr,
  output logic [7:0]   wbase_addr,
  input  logic [7:0]   vmx_addr,
  input  logic         vmx_wr_en,
  output logic [63:0]  vmx_d_i,
  input  logic [127:0] vmx_d_o,
  output logic [31:0]  vmx_ctrl,
  input  logic [31:0]  vmx_flag
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] LAST_IN = 8'(N_IN - 1);
  localparam logic [7:0] LAST_OUT = 8'(N_OUT - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_ARM, ST_RUN, ST_DRAIN, ST_ABORT} state_t;
  state_t state, state_d;
  logic [7:0] rbase, wbase, cnt;
  logic [TW-1:0] timer;
  logic [63:0] in_mem [256];
  logic [127:0] res_mem [256];
  assign busy = state != ST_IDLE;
  assign s_ready = state == ST_FILL;
  assign m_last = m_valid && cnt == LAST_OUT;
  assign rbase_addr = rbase;
  assign wbase_addr = wbase;
  assign vmx_d_i = in_mem[vmx_addr];
  assign vmx_ctrl = {30'd0, state == ST_ARM && timer == '0, state == ST_ABORT};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  state_d = go ? ST_FILL : ST_IDLE;
      ST_FILL:  state_d = s_valid && cnt == LAST_IN ? ST_ARM : ST_FILL;
      ST_ARM:   state_d = vmx_flag != 0 ? ST_RUN : timer == T_LAST ? ST_ABORT : ST_ARM;
      ST_RUN:   state_d = vmx_flag == 0 ? ST_DRAIN : timer == T_LAST ? ST_ABORT : ST_RUN;
      ST_DRAIN: state_d = m_valid && m_ready && cnt == LAST_OUT ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rbase <= '0;
      wbase <= '0;
      cnt <= '0;
      timer <= '0;
      err <= 1'b0;
      done <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
    end else begin
      done <= 1'b0;
      timer <= state_d == state ? timer + 1'b1 : '0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (go) begin
            rbase <= cfg_rbase;
            wbase <= cfg_wbase;
            err <= 1'b0;
          end
        end
        ST_FILL: if (s_valid) cnt <= cnt + 8'd1;
        ST_DRAIN:
          if (!m_valid) begin
            m_data <= res_mem[wbase + cnt];
            m_valid <= 1'b1;
          end else if (m_ready) begin
            cnt <= cnt + 8'd1;
            m_valid <= cnt != LAST_OUT;
            done <= cnt == LAST_OUT;
            m_data <= res_mem[wbase + cnt + 8'd1];
          end
        ST_ABORT: err <= 1'b1;
        default: cnt <= '0;
      endcase
    end
  always_ff @(posedge clk) begin
    if (state == ST_FILL && s_valid) in_mem[rbase + cnt] <= s_data;
    if (vmx_wr_en) res_mem[vmx_addr] <= vmx_d_o;
  end
endmodule

// File: tb/tb_vmx_buf_host.sv
// tb_vmx_buf_host: randomized jobs against a queue/array model of the buffers and result stream
module tb_vmx_buf_host;
  logic clk = 0, rst_n = 0, go = 0;
  logic [7:0] cfg_rbase = 0, cfg_wbase = 0;
  logic busy, done, err, s_ready, m_valid, m_last;
  logic s_valid = 0, m_ready = 0, vmx_wr_en = 0;
  logic [63:0] s_data = 0, vmx_d_i;
  logic [127:0] m_data, vmx_d_o = 0;
  logic [7:0] rbase_addr, wbase_addr, vmx_addr = 0;
  logic [31:0] vmx_ctrl, vmx_flag = 0;
  int tests = 0, fails = 0;
  logic [63:0] exp_in [256];
  bit exp_in_v [256];
  logic [127:0] exp_q [$], got [$], prev_data, e;
  logic [7:0] exp_rb = 0, exp_wb = 0;
  bit in_fill = 0, wr_active = 0, pend_done = 0, prev_mv = 0, prev_rdy = 0;
  int c1_cnt = 0, c0_cnt = 0, done_cnt = 0, rdy_mode = 1, pi = 0;
  bit [3:0] pat = 4'b1001;

  vmx_buf_host #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cfg_rbase(cfg_rbase), .cfg_wbase(cfg_wbase),
    .busy(busy), .done(done), .err(err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .rbase_addr(rbase_addr), .wbase_addr(wbase_addr), .vmx_addr(vmx_addr), .vmx_wr_en(vmx_wr_en),
    .vmx_d_i(vmx_d_i), .vmx_d_o(vmx_d_o), .vmx_ctrl(vmx_ctrl), .vmx_flag(vmx_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!wr_active) vmx_addr = 8'($urandom);
    case (rdy_mode)
      0: m_ready = 1'($urandom_range(0, 1));
      1: m_ready = 1'b1;
      default: begin m_ready = pat[pi % 4]; pi++; end
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mv = 0;
      pend_done = 0;
    end else begin
      if (vmx_ctrl[1]) c1_cnt++;
      if (vmx_ctrl[0]) c0_cnt++;
      if (done) done_cnt++;
      chk("done", done, pend_done);
      pend_done = 0;
      chk("s_ready", s_ready, in_fill);
      chk("rbase_addr", rbase_addr, exp_rb);
      chk("wbase_addr", wbase_addr, exp_wb);
      chk("ctrl_upper", vmx_ctrl[31:2], 0);
      if (exp_in_v[vmx_addr]) chk("vmx_d_i", vmx_d_i, exp_in[vmx_addr]);
      if (prev_mv && !prev_rdy) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (!m_valid) chk("m_last_no_valid", m_last, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_word", m_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e);
          chk("m_last", m_last, exp_q.size() == 0);
          pend_done = exp_q.size() == 0;
          got.push_back(m_data);
        end
      end
      prev_mv = m_valid;
      prev_rdy = m_ready;
      prev_data = m_data;
    end
  end

  task automatic start_job(input logic [7:0] rb, input logic [7:0] wb);
    cfg_rbase = rb;
    cfg_wbase = wb;
    go = 1;
    @(posedge clk);
    #1;
    go = 0;
    exp_rb = rb;
    exp_wb = wb;
    in_fill = 1;
    chk("err_clear", err, 0);
  endtask

  task automatic send_word(input logic [63:0] w, input logic [7:0] a);
    int n = 0;
    s_valid = 1;
    s_data = w;
    @(negedge clk);
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    if (!s_ready) chk("fill_ready", s_ready, 1);
    @(posedge clk);
    #1;
    exp_in[a] = w;
    exp_in_v[a] = 1;
  endtask

  task automatic run_job(input logic [7:0] rb, input logic [7:0] wb, input int mode);
    logic [63:0] w;
    logic [127:0] d;
    int n;
    c1_cnt = 0; c0_cnt = 0; done_cnt = 0;
    got.delete();
    if (mode == 1) begin
      s_valid = 1;
      s_data = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    start_job(rb, wb);
    for (int i = 0; i < 8; i++) begin
      if (mode == 1)
        repeat ($urandom_range(0, 2)) begin
          s_valid = 0;
          go = 1'($urandom_range(0, 1));
          cfg_rbase = 8'($urandom);
          cfg_wbase = 8'($urandom);
          @(posedge clk);
          #1;
        end
      w = mode == 1 ? {$urandom, $urandom} : 64'h0101 * (i + 1);
      send_word(w, rb + 8'(i));
    end
    go = 0;
    in_fill = 0;
    s_valid = mode == 1;
    s_data = {$urandom, $urandom};
    n = 0;
    @(negedge clk);
    while (!vmx_ctrl[1] && n < 5) begin @(negedge clk); n++; end
    chk("arm_pulse_lat", n, 0);
    wr_active = 1;
    if (mode == 2) begin
      n = 0;
      while (!err && n < 40) begin @(negedge clk); n++; end
      chk("timeout_cycles", n, 16);
      chk("abort_pulses", c0_cnt, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done_cnt, 0);
      chk("abort_start_pulses", c1_cnt, 1);
      wr_active = 0;
      return;
    end
    @(posedge clk);
    #1;
    vmx_flag = 1;
    for (int i = 0; i < 8; i++) begin
      vmx_addr = rb + 8'(i);
      @(posedge clk);
      #1;
    end
    if (mode == 3) begin
      vmx_flag = 2;
      @(posedge clk);
      #2;
      rst_n = 0;
      exp_rb = 0;
      exp_wb = 0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_ctrl", vmx_ctrl, 0);
      chk("rst_rbase", rbase_addr, 0);
      vmx_flag = 0;
      wr_active = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      chk("rst_done_cnt", done_cnt, 0);
      s_valid = 0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      vmx_flag = k < 3 ? k + 2 : 4;
      vmx_wr_en = 1;
      vmx_addr = wb + 8'(k);
      d = mode == 1 ? {$urandom, $urandom, $urandom, $urandom} : 128'h1111 * (k + 1);
      vmx_d_o = d;
      @(posedge clk);
      #1;
      exp_q.push_back(d);
    end
    vmx_wr_en = 0;
    vmx_flag = 0;
    wr_active = 0;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("start_pulses", c1_cnt, 1);
    chk("abort_none", c0_cnt, 0);
    chk("job_err", err, 0);
    chk("job_busy", busy, 0);
    s_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {busy, done, err, s_ready, m_valid, m_last}, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_ctrl", vmx_ctrl, 0);
    chk("reset_bases", {rbase_addr, wbase_addr}, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    run_job(8'h10, 8'h80, 0);
    chk("lit_cnt", got.size(), 4);
    chk("lit_w0", got[0], 128'h1111);
    chk("lit_w3", got[3], 128'h4444);
    wr_active = 1;
    vmx_addr = 8'h10;
    #1 chk("lit_in_10", vmx_d_i, 64'h0101);
    vmx_addr = 8'h17;
    #1 chk("lit_in_17", vmx_d_i, 64'h0808);
    wr_active = 0;
    run_job(8'hFE, 8'h84, 0);
    wr_active = 1;
    vmx_addr = 8'hFE;
    #1 chk("wrap_fe", vmx_d_i, 64'h0101);
    vmx_addr = 8'h00;
    #1 chk("wrap_00", vmx_d_i, 64'h0303);
    vmx_addr = 8'h05;
    #1 chk("wrap_05", vmx_d_i, 64'h0808);
    wr_active = 0;
    rdy_mode = 2;
    run_job(8'h40, 8'hC0, 1);
    rdy_mode = 1;
    run_job(8'h20, 8'h90, 2);
    chk("err_sticky", err, 1);
    run_job(8'h28, 8'h98, 1);
    run_job(8'h50, 8'hA0, 3);
    run_job(8'h58, 8'hA8, 1);
    for (int r = 0; r < 10; r++) begin
      rdy_mode = $urandom_range(0, 2);
      run_job(8'($urandom), 8'($urandom), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
